relu_backward: RTL and testbench
================================

RELU_BACKWARD -- requirements
Module: relu_backward

Interface
REQ-001 Parameters SHALL be: VECTOR_LEN, default 3, elements per vector; COUNT, default 1, vectors per batch; LEAK_SHIFT, default 3, arithmetic right-shift applied to masked gradients when leaky mode is compiled in.
REQ-002 Ports SHALL be, one line each:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- abort  in  1  synchronous flush to CAPTURE.
- fwd_valid  in  1  forward pre-activation element valid.
- fwd_ready  out  1  block accepts forward element.
- fwd_data  in  32  signed pre-activation element, two's complement.
- grad_in_valid  in  1  upstream gradient valid.
- grad_in_ready  out  1  block accepts upstream gradient.
- grad_in_data  in  32  signed upstream gradient.
- grad_out_valid  out  1  downstream gradient valid.
- grad_out_ready  in  1  consumer accepts downstream gradient.
- grad_out_data  out  32  signed downstream gradient.
- grad_out_last  out  1  marks element N-1 of the batch.
- mask_full  out  1  high while in BACKWARD.
REQ-003 N SHALL equal COUNT*VECTOR_LEN; elements SHALL stream row-major (vector i, element j at index i*VECTOR_LEN+j).

Function
REQ-004 The FSM SHALL have exactly two states: CAPTURE and BACKWARD.
REQ-005 CAPTURE: fwd_ready=1, grad_in_ready=0; each fwd handshake SHALL store mask[idx] = NOT fwd_data[31] and increment idx.
REQ-006 The handshake with idx=N-1 SHALL clear idx and enter BACKWARD on the next cycle.
REQ-007 Zero input SHALL set its mask bit to 1, and 0x80000000 SHALL set it to 0.
REQ-008 BACKWARD: fwd_ready=0, mask_full=1, grad_in_ready = NOT grad_out_valid OR grad_out_ready.
REQ-009 Each grad_in handshake SHALL load the output register on the next edge: grad_out_data = grad_in_data if mask[idx] is 1, otherwise the masked value (REQ-016/017); grad_out_last = (idx==N-1); idx increments.
REQ-010 Latency SHALL be 1 cycle from grad_in handshake to grad_out_valid; sustained throughput SHALL be 1 element/cycle while grad_out_ready=1.
REQ-011 grad_out_valid SHALL clear on an output handshake unless a new input handshake occurs in the same cycle; grad_out_data/last SHALL be held stable while valid and not ready.
REQ-012 After the last input handshake (idx=N-1), grad_in_ready SHALL be 0; the FSM SHALL return to CAPTURE in the cycle after the output handshake with grad_out_last=1, with idx=0.
REQ-013 abort=1 SHALL take priority over all handshakes: on the next edge state=CAPTURE, idx=0, grad_out_valid=0; that cycle's fwd/grad transfers SHALL be discarded.
REQ-014 The mask SHALL NOT be cleared by abort or by completion; it is only overwritten by the next capture.

Reset
REQ-015 When rst=1 at an edge: state=CAPTURE, idx=0, grad_out_valid=0, grad_out_data=0, grad_out_last=0, mask=all 0; rst SHALL take priority over abort. Outputs after reset: fwd_ready=1, grad_in_ready=0, mask_full=0.

Configuration
REQ-016 With RELU_BACKWARD_LEAKY_EN defined, a masked gradient SHALL output grad_in_data >>> LEAK_SHIFT (arithmetic, sign-preserving, truncated toward minus infinity).
REQ-017 Without RELU_BACKWARD_LEAKY_EN, a masked gradient SHALL output 0, and LEAK_SHIFT SHALL be unused.

Verification
REQ-018 Defaults, capture {5, -2, 0}, then gradients {10, 10, 10} with ready=1 -> outputs {10, 0, 10}, last on the third output, and CAPTURE re-entered 1 cycle later.
REQ-019 Leaky build, capture {-1, 0x80000000, 7}, gradients {64, -64, 9} -> outputs {8, -8, 9}.
REQ-020 Hold grad_out_ready=0 for 4 cycles mid-batch -> grad_in_ready=0, output stable, no element lost or duplicated.
REQ-021 Assert abort at the second gradient handshake -> next cycle grad_out_valid=0, fwd_ready=1, idx=0; a new capture proceeds normally.
REQ-022 COUNT=2, VECTOR_LEN=2, capture {1, -1, -1, 1}, gradients all 3 -> outputs {3, 0, 0, 3}.
REQ-023 Assert rst during BACKWARD with grad_out_valid=1 -> next cycle all REQ-015 values are present, and the next batch's gradients are gated by all-0 mask bits until recapture.

Source files
------------

// File: rtl/relu_backward.sv
// relu_backward: ReLU backward pass over a batch of N = COUNT*VECTOR_LEN elements.
// The CAPTURE state records one sign bit per forward element. The BACKWARD state
// then streams the upstream gradients through that mask into a single output register.
// Optional feature macro: RELU_BACKWARD_LEAKY_EN. When it is defined, a masked
// gradient is scaled by an arithmetic right shift of LEAK_SHIFT instead of being zeroed.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// A producer holds valid and data stable until that transfer. The output register
// holds grad_out_data and grad_out_last stable while grad_out_valid=1 and grad_out_ready=0.
module relu_backward #(
   parameter int VECTOR_LEN = 3,
   parameter int COUNT      = 1,
   parameter int LEAK_SHIFT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        abort,
   input  logic        fwd_valid,
   output logic        fwd_ready,
   input  logic [31:0] fwd_data,
   input  logic        grad_in_valid,
   output logic        grad_in_ready,
   input  logic [31:0] grad_in_data,
   output logic        grad_out_valid,
   input  logic        grad_out_ready,
   output logic [31:0] grad_out_data,
   output logic        grad_out_last,
   output logic        mask_full
);

   localparam int N     = COUNT * VECTOR_LEN;
   // idx can reach N in BACKWARD, meaning every gradient has been accepted.
   localparam int IDX_W = $clog2(N + 1);

`ifdef RELU_BACKWARD_LEAKY_EN
   localparam bit LEAKY = 1'b1;
`else
   localparam bit LEAKY = 1'b0;
`endif

   typedef enum logic {
      CAPTURE  = 1'b0,
      BACKWARD = 1'b1
   } state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [N-1:0]       mask_q;
   logic [N-1:0]       mask_d;
   logic               gout_valid_q;
   logic [31:0]        gout_data_q;
   logic               gout_last_q;

   logic               mask_bit;
   logic               idx_last;
   logic               in_pending;
   logic               fwd_fire;
   logic               gin_fire;
   logic               gout_fire;
   logic [31:0]        shifted;
   logic [31:0]        gout_data_d;

   assign fwd_ready      = (state_q == CAPTURE);
   assign mask_full      = (state_q == BACKWARD);
   assign in_pending     = (idx_q < IDX_W'(N));
   assign grad_in_ready  = (state_q == BACKWARD) && in_pending &&
                           (!gout_valid_q || grad_out_ready);
   assign grad_out_valid = gout_valid_q;
   assign grad_out_data  = gout_data_q;
   assign grad_out_last  = gout_last_q;

   assign fwd_fire  = fwd_valid && fwd_ready;
   assign gin_fire  = grad_in_valid && grad_in_ready;
   assign gout_fire = gout_valid_q && grad_out_ready;
   assign idx_last  = (idx_q == IDX_W'(N - 1));
   assign shifted   = $signed(grad_in_data) >>> LEAK_SHIFT;

   // Mask lookup and mask update, both addressed by the current element index
   always_comb begin
      mask_bit = 1'b0;
      mask_d   = mask_q;
      for (int k = 0; k < N; k++) begin
         if (idx_q == IDX_W'(k)) begin
            mask_bit  = mask_q[k];
            mask_d[k] = ($signed(fwd_data) >= 32'sd0);
         end
      end
      gout_data_d = mask_bit ? grad_in_data : (LEAKY ? shifted : 32'd0);
   end

   // FSM, element index, sign mask and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= CAPTURE;
         idx_q        <= '0;
         mask_q       <= '0;
         gout_valid_q <= 1'b0;
         gout_data_q  <= '0;
         gout_last_q  <= 1'b0;
      end else if (abort) begin
         // Flush: the transfers of this cycle are dropped, and the mask is kept
         state_q      <= CAPTURE;
         idx_q        <= '0;
         gout_valid_q <= 1'b0;
      end else begin
         case (state_q)
            CAPTURE: begin
               if (fwd_fire) begin
                  mask_q <= mask_d;
                  if (idx_last) begin
                     idx_q   <= '0;
                     state_q <= BACKWARD;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            BACKWARD: begin
               if (gin_fire) begin
                  gout_valid_q <= 1'b1;
                  gout_data_q  <= gout_data_d;
                  gout_last_q  <= idx_last;
                  idx_q        <= idx_q + IDX_W'(1);
               end else if (gout_fire) begin
                  gout_valid_q <= 1'b0;
                  // No input can be accepted once the last element is out
                  if (gout_last_q) begin
                     state_q <= CAPTURE;
                     idx_q   <= '0;
                  end
               end
            end
            default: state_q <= CAPTURE;
         endcase
      end
   end

endmodule

// File: tb/tb_relu_backward.sv
// Bench for relu_backward with the default geometry (N = 3).
// Build with RELU_BACKWARD_LEAKY_EN defined to exercise the leaky reference path.
module tb_relu_backward;

   localparam int VL = 3;
   localparam int CNT = 1;
   localparam int LS = 3;
   localparam int N = VL * CNT;

   logic        clk = 1'b0;
   logic        rst, abort;
   logic        fwd_valid, fwd_ready;
   logic [31:0] fwd_data;
   logic        grad_in_valid, grad_in_ready;
   logic [31:0] grad_in_data;
   logic        grad_out_valid, grad_out_ready;
   logic [31:0] grad_out_data;
   logic        grad_out_last;
   logic        mask_full;

   int          n_checks = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   logic [32:0] exp_q[$];            // {last, data}
   bit          model_mask[N];
   logic [31:0] cap_vals[N];
   logic [31:0] grad_vals[N];

   relu_backward #(.VECTOR_LEN(VL), .COUNT(CNT), .LEAK_SHIFT(LS)) dut (
      .clk(clk), .rst(rst), .abort(abort),
      .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
      .grad_in_valid(grad_in_valid), .grad_in_ready(grad_in_ready),
      .grad_in_data(grad_in_data),
      .grad_out_valid(grad_out_valid), .grad_out_ready(grad_out_ready),
      .grad_out_data(grad_out_data), .grad_out_last(grad_out_last),
      .mask_full(mask_full)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: pass when the forward value was non-negative, otherwise zero
   // (or floor(g / 2^LS) in the leaky build)
   function automatic logic [31:0] ref_grad(input bit m, input logic [31:0] g);
      longint gv, d, q;
      gv = longint'($signed(g));
      d  = longint'(1) << LS;
      q  = gv / d;
      if ((gv % d) != 0 && gv < 0) q = q - 1;
      if (m) return g;
`ifdef RELU_BACKWARD_LEAKY_EN
      return q[31:0];
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'h7fff_ffff;
         3: return 32'hffff_ffff;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: output valid must track outstanding expectations; compare and pop on transfer
   always @(negedge clk) begin
      if (mon_en) begin
         check("out_valid", 33'(grad_out_valid), 33'(exp_q.size() > 0));
         if (grad_out_valid && exp_q.size() > 0) begin
            check("out_data_last", {grad_out_last, grad_out_data}, exp_q[0]);
            if (grad_out_ready) void'(exp_q.pop_front());
         end
         if (rst || abort) exp_q.delete();
      end
   end

   // Driver: stream cap_vals into the forward port; abort at handshake abort_at restarts it
   task automatic capture_batch(input int abort_at, input bit gaps);
      int k, cyc, ab_at;
      bit hs, ab;
      k = 0; cyc = 0; ab_at = abort_at;
      while (k < N && cyc < 200) begin
         fwd_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         fwd_data  = cap_vals[k];
         ab        = (k == ab_at) && fwd_valid;
         abort     = ab;
         @(negedge clk);
         check("cap_fwd_ready", 33'(fwd_ready), 33'd1);
         check("cap_grad_in_ready", 33'(grad_in_ready), 33'd0);
         check("cap_mask_full", 33'(mask_full), 33'd0);
         hs = fwd_valid && fwd_ready;
         @(posedge clk); #1;
         fwd_valid = 1'b0;
         abort     = 1'b0;
         if (ab) begin
            ab_at = -1;
            k = 0;
         end else if (hs) begin
            model_mask[k] = (int'($signed(cap_vals[k])) >= 0);
            k++;
         end
         cyc++;
      end
      check("cap_timeout", 33'(k), 33'(N));
      @(negedge clk);
      check("cap_done_fwd_ready", 33'(fwd_ready), 33'd0);
      check("cap_done_mask_full", 33'(mask_full), 33'd1);
      @(posedge clk); #1;
   endtask

   // Driver: stream grad_vals; mode 0 ready=1, 1 random, 2 ready held low 4 cycles
   task automatic grad_batch(input int mode, input int abort_at);
      int k, cyc;
      bit hs, ab, lastpop, done;
      k = 0; cyc = 0; done = 1'b0;
      while (!done && cyc < 300) begin
         grad_in_valid = (k < N) && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
         grad_in_data  = (k < N) ? grad_vals[k] : $urandom;
         case (mode)
            0: grad_out_ready = 1'b1;
            1: grad_out_ready = ($urandom_range(0, 2) != 0);
            default: grad_out_ready = !(cyc >= 2 && cyc < 6);
         endcase
         ab    = (k == abort_at) && grad_in_valid;
         abort = ab;
         @(negedge clk);
         check("bwd_mask_full", 33'(mask_full), 33'd1);
         check("bwd_fwd_ready", 33'(fwd_ready), 33'd0);
         if (grad_out_valid && !grad_out_ready)
            check("bwd_in_ready_stall", 33'(grad_in_ready), 33'd0);
         if (!grad_out_valid && k < N)
            check("bwd_in_ready_idle", 33'(grad_in_ready), 33'd1);
         if (k == N)
            check("bwd_in_ready_done", 33'(grad_in_ready), 33'd0);
         hs      = grad_in_valid && grad_in_ready;
         lastpop = grad_out_valid && grad_out_ready && grad_out_last;
         @(posedge clk); #1;
         grad_in_valid = 1'b0;
         abort         = 1'b0;
         if (ab) begin
            done = 1'b1;
         end else begin
            if (hs) begin
               exp_q.push_back({(k == N - 1), ref_grad(model_mask[k], grad_vals[k])});
               k++;
            end
            if (lastpop) done = 1'b1;
         end
         cyc++;
      end
      check("bwd_timeout", 33'(done), 33'd1);
      @(negedge clk);
      check("end_fwd_ready", 33'(fwd_ready), 33'd1);
      check("end_mask_full", 33'(mask_full), 33'd0);
      check("end_grad_in_ready", 33'(grad_in_ready), 33'd0);
      check("end_out_valid", 33'(grad_out_valid), 33'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_values();
      check("rst_fwd_ready", 33'(fwd_ready), 33'd1);
      check("rst_grad_in_ready", 33'(grad_in_ready), 33'd0);
      check("rst_mask_full", 33'(mask_full), 33'd0);
      check("rst_out_valid", 33'(grad_out_valid), 33'd0);
      check("rst_out_data", 33'(grad_out_data), 33'd0);
      check("rst_out_last", 33'(grad_out_last), 33'd0);
   endtask

   task automatic random_vectors();
      for (int i = 0; i < N; i++) begin
         cap_vals[i]  = rand_val();
         grad_vals[i] = rand_val();
      end
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus sequence
   initial begin
      rst = 1'b1; abort = 1'b0;
      fwd_valid = 1'b0; fwd_data = '0;
      grad_in_valid = 1'b0; grad_in_data = '0; grad_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_values();
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Mixed signs including zero
      cap_vals  = '{32'd5, -32'sd2, 32'd0};
      grad_vals = '{32'd10, 32'd10, 32'd10};
      capture_batch(-1, 1'b0);
      grad_batch(0, -1);

      // Negative and most-negative forward values, signed gradients
      cap_vals  = '{32'hffff_ffff, 32'h8000_0000, 32'd7};
      grad_vals = '{32'd64, -32'sd64, 32'd9};
      capture_batch(-1, 1'b0);
      grad_batch(0, -1);

      // Consumer stall mid-batch
      random_vectors();
      capture_batch(-1, 1'b1);
      grad_batch(2, -1);

      // Abort at the second gradient handshake, then a normal batch
      random_vectors();
      capture_batch(-1, 1'b0);
      grad_batch(0, 1);
      random_vectors();
      capture_batch(-1, 1'b1);
      grad_batch(0, -1);

      // Abort during capture restarts the capture from element 0
      random_vectors();
      capture_batch(1, 1'b0);
      grad_batch(1, -1);

      // Reset while an output is pending
      random_vectors();
      capture_batch(-1, 1'b0);
      grad_in_valid  = 1'b1;
      grad_in_data   = grad_vals[0];
      grad_out_ready = 1'b0;
      @(negedge clk);
      check("pre_rst_in_ready", 33'(grad_in_ready), 33'd1);
      @(posedge clk); #1;
      grad_in_valid = 1'b0;
      exp_q.push_back({(N == 1), ref_grad(model_mask[0], grad_vals[0])});
      @(negedge clk);
      check("pre_rst_out_valid", 33'(grad_out_valid), 33'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) model_mask[i] = 1'b0;
      @(negedge clk);
      check_reset_values();
      @(posedge clk); #1;
      random_vectors();
      capture_batch(-1, 1'b0);
      grad_batch(0, -1);

      // Randomized batches
      for (int b = 0; b < 20; b++) begin
         random_vectors();
         capture_batch(-1, 1'(b % 2));
         grad_batch(int'($urandom_range(0, 2)), -1);
      end

      repeat (3) @(negedge clk);
      check("final_queue_empty", 33'(exp_q.size()), 33'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
